midi_voice_alloc: RTL and testbench

//  Consumes the key strobe and 7-bit key index from the MIDI serial receiver and tracks held notes.
//  - A strobe on a key that no voice holds turns that key on in a voice slot.
//  - A strobe on a key that a voice already holds turns that key off.

---
 rtl/midi_voice_alloc.sv | 194 +++++++++++++++++++
 tb/tb_midi_voice_alloc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_alloc.sv
// MIDI key-to-voice allocator: toggles held keys across NUM_VOICES slots with per-slot age
// and optional auto-release. Define VOICE_STEAL_EN to steal the oldest slot on a full-table miss.
module midi_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 16,
    parameter int TIMEOUT    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_valid,
    input  logic [6:0]              key_index,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [7*NUM_VOICES-1:0] voice_key,
    output logic [NUM_VOICES-1:0]   voice_on,
    output logic [NUM_VOICES-1:0]   voice_off,
    output logic                    busy,
    output logic                    drop
);

    localparam int unsigned NV    = NUM_VOICES;
    localparam int          IDX_W = $clog2(NUM_VOICES);

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, SEARCH, UPDATE} state_t;

    state_t state, state_next;

    logic [6:0]        key_q;
    logic [6:0]        keys   [NUM_VOICES];
    logic [6:0]        keys_n [NUM_VOICES];
    logic [AGE_W-1:0]  age    [NUM_VOICES];
    logic [AGE_W-1:0]  age_n  [NUM_VOICES];
    logic [NV-1:0]     active_n, on_n, off_n;
    logic              drop_n;

    logic hit_found, free_found, hit_found_q, free_found_q;
    idx_t hit_idx, free_idx, hit_idx_q, free_idx_q;
`ifdef VOICE_STEAL_EN
    logic             oldest_found;
    logic [AGE_W-1:0] oldest_age;
    idx_t             oldest_idx, oldest_idx_q;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (key_valid) state_next = SEARCH;
            SEARCH:  state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NV; i++) begin
            if (!hit_found && voice_active[i] && (keys[i] == key_q)) begin
                hit_found = 1'b1;
                hit_idx   = idx_t'(i);
            end
            if (!free_found && !voice_active[i]) begin
                free_found = 1'b1;
                free_idx   = idx_t'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Strict '>' keeps the lowest index on equal ages.
    always_comb begin
        oldest_found = 1'b0;
        oldest_age   = '0;
        oldest_idx   = '0;
        for (int unsigned i = 0; i < NV; i++) begin
            if (voice_active[i] && (!oldest_found || (age[i] > oldest_age))) begin
                oldest_found = 1'b1;
                oldest_age   = age[i];
                oldest_idx   = idx_t'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            key_q        <= '0;
            hit_found_q  <= 1'b0;
            hit_idx_q    <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
`ifdef VOICE_STEAL_EN
            oldest_idx_q <= '0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && key_valid) begin
                key_q <= key_index;
            end
            if (state == SEARCH) begin
                hit_found_q  <= hit_found;
                hit_idx_q    <= hit_idx;
                free_found_q <= free_found;
                free_idx_q   <= free_idx;
`ifdef VOICE_STEAL_EN
                oldest_idx_q <= oldest_idx;
`endif
            end
        end
    end

    // UPDATE acts on the SEARCH snapshot; a slot already timed out in between gets no second voice_off.
    always_comb begin
        active_n = voice_active;
        keys_n   = keys;
        on_n     = '0;
        off_n    = '0;
        drop_n   = 1'b0;
        for (int unsigned i = 0; i < NV; i++) begin
            if (voice_active[i]) begin
                age_n[i] = (age[i] == '1) ? age[i] : age[i] + AGE_W'(1);
            end else begin
                age_n[i] = '0;
            end
            if ((TIMEOUT != 0) && voice_active[i] && (age[i] == AGE_W'(TIMEOUT))) begin
                active_n[i] = 1'b0;
                off_n[i]    = 1'b1;
                age_n[i]    = '0;
            end
        end

        if (state == UPDATE) begin
            if (hit_found_q) begin
                if (voice_active[hit_idx_q]) begin
                    active_n[hit_idx_q] = 1'b0;
                    off_n[hit_idx_q]    = 1'b1;
                    age_n[hit_idx_q]    = '0;
                end
            end else if (free_found_q) begin
                active_n[free_idx_q] = 1'b1;
                keys_n[free_idx_q]   = key_q;
                age_n[free_idx_q]    = '0;
                on_n[free_idx_q]     = 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
                off_n[oldest_idx_q]    = voice_active[oldest_idx_q];
                on_n[oldest_idx_q]     = 1'b1;
                active_n[oldest_idx_q] = 1'b1;
                keys_n[oldest_idx_q]   = key_q;
                age_n[oldest_idx_q]    = '0;
`else
                drop_n = 1'b1;
`endif
            end
        end

        if (key_valid && state != IDLE) begin
            drop_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voice_active <= '0;
            voice_on     <= '0;
            voice_off    <= '0;
            drop         <= 1'b0;
            for (int unsigned i = 0; i < NV; i++) begin
                keys[i] <= '0;
                age[i]  <= '0;
            end
        end else begin
            voice_active <= active_n;
            voice_on     <= on_n;
            voice_off    <= off_n;
            drop         <= drop_n;
            keys         <= keys_n;
            age          <= age_n;
        end
    end

    always_comb begin
        voice_key = '0;
        for (int unsigned i = 0; i < NV; i++) begin
            voice_key[7*i +: 7] = keys[i];
        end
    end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Self-checking bench for midi_voice_alloc: table of key strobes with a scoreboard queue,
// plus hand sequences for busy drop, full table, reset mid-search and timeout.
module tb_midi_voice_alloc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kv, kv2;
    logic [6:0]  ki, ki2;
    logic [3:0]  va, von, voff, va2, von2, voff2;
    logic [27:0] vk, vk2;
    logic        busy, drop, busy2, drop2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    midi_voice_alloc #(.NUM_VOICES(4), .AGE_W(16), .TIMEOUT(0)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(kv), .key_index(ki),
        .voice_active(va), .voice_key(vk), .voice_on(von), .voice_off(voff),
        .busy(busy), .drop(drop)
    );

    midi_voice_alloc #(.NUM_VOICES(4), .AGE_W(16), .TIMEOUT(100)) dut_to (
        .clk(clk), .rst_n(rst_n), .key_valid(kv2), .key_index(ki2),
        .voice_active(va2), .voice_key(vk2), .voice_on(von2), .voice_off(voff2),
        .busy(busy2), .drop(drop2)
    );

    typedef struct packed {
        logic [6:0]  key;
        logic [3:0]  act;
        logic [3:0]  on;
        logic [3:0]  off;
        logic [27:0] keys;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    vec_t e;
    int   cnt;

    function automatic logic [27:0] kk(input logic [6:0] s0, input logic [6:0] s1,
                                       input logic [6:0] s2, input logic [6:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    function automatic vec_t mk(input logic [6:0] k, input logic [3:0] a, input logic [3:0] n,
                                input logic [3:0] f, input logic [27:0] ks);
        vec_t v;
        v.key = k; v.act = a; v.on = n; v.off = f; v.keys = ks;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic strobe(input logic [6:0] k);
        @(negedge clk); kv = 1'b1; ki = k;
        @(negedge clk); kv = 1'b0;
    endtask

    task automatic strobe_to(input logic [6:0] k);
        @(negedge clk); kv2 = 1'b1; ki2 = k;
        @(negedge clk); kv2 = 1'b0;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0; kv = 1'b0; kv2 = 1'b0; ki = '0; ki2 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(7'd60,  4'b0001, 4'b0001, 4'b0000, kk(7'd60, 7'd0,  7'd0, 7'd0));
        vecs[1] = mk(7'd64,  4'b0011, 4'b0010, 4'b0000, kk(7'd60, 7'd64, 7'd0, 7'd0));
        vecs[2] = mk(7'd60,  4'b0010, 4'b0000, 4'b0001, kk(7'd60, 7'd64, 7'd0, 7'd0));
        vecs[3] = mk(7'd60,  4'b0011, 4'b0001, 4'b0000, kk(7'd60, 7'd64, 7'd0, 7'd0));
        vecs[4] = mk(7'd0,   4'b0111, 4'b0100, 4'b0000, kk(7'd60, 7'd64, 7'd0, 7'd0));
        vecs[5] = mk(7'd127, 4'b1111, 4'b1000, 4'b0000, kk(7'd60, 7'd64, 7'd0, 7'd127));
        vecs[6] = mk(7'd0,   4'b1011, 4'b0000, 4'b0100, kk(7'd60, 7'd64, 7'd0, 7'd127));
        vecs[7] = mk(7'd5,   4'b1111, 4'b0100, 4'b0000, kk(7'd60, 7'd64, 7'd5, 7'd127));
        vecs[8] = mk(7'd127, 4'b0111, 4'b0000, 4'b1000, kk(7'd60, 7'd64, 7'd5, 7'd127));
        vecs[9] = mk(7'd64,  4'b0101, 4'b0000, 4'b0010, kk(7'd60, 7'd64, 7'd5, 7'd127));

        rst_n = 1'b0; kv = 1'b0; kv2 = 1'b0; ki = '0; ki2 = '0;
        reset_all();
        chk("rst_active", 32'(va),   32'd0);
        chk("rst_key",    32'(vk),   32'd0);
        chk("rst_on",     32'(von),  32'd0);
        chk("rst_off",    32'(voff), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_drop",   32'(drop), 32'd0);
        chk("rst_to_active", 32'(va2), 32'd0);

        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(vecs[i]);
            strobe(vecs[i].key);
            @(negedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d_active", i), 32'(va),   32'(e.act));
            chk($sformatf("v%0d_keys", i),   32'(vk),   32'(e.keys));
            chk($sformatf("v%0d_on", i),     32'(von),  32'(e.on));
            chk($sformatf("v%0d_off", i),    32'(voff), 32'(e.off));
            chk($sformatf("v%0d_drop", i),   32'(drop), 32'd0);
            chk($sformatf("v%0d_busy", i),   32'(busy), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_on_end", i),  32'(von),  32'd0);
            chk($sformatf("v%0d_off_end", i), 32'(voff), 32'd0);
        end

        // strobes during SEARCH and UPDATE are both discarded
        reset_all();
        kv = 1'b1; ki = 7'd60;
        @(negedge clk);
        chk("busy_search", 32'(busy), 32'd1);
        ki = 7'd61;
        @(negedge clk);
        chk("drop_search", 32'(drop), 32'd1);
        ki = 7'd62;
        @(negedge clk);
        kv = 1'b0;
        chk("drop_update",   32'(drop), 32'd1);
        chk("busy_active",   32'(va),   32'b0001);
        chk("busy_key",      32'(vk),   32'(kk(7'd60, 7'd0, 7'd0, 7'd0)));
        chk("busy_on",       32'(von),  32'b0001);
        repeat (4) @(negedge clk);
        chk("busy_drop_end", 32'(drop), 32'd0);
        chk("busy_only60",   32'(va),   32'b0001);

        // full table miss
        reset_all();
        strobe(7'd60); repeat (3) @(negedge clk);
        strobe(7'd62); repeat (3) @(negedge clk);
        strobe(7'd64); repeat (3) @(negedge clk);
        strobe(7'd65); repeat (3) @(negedge clk);
        chk("full_active", 32'(va), 32'b1111);
        strobe(7'd67);
        @(negedge clk);
        @(negedge clk);
        chk("full_active2", 32'(va), 32'b1111);
`ifdef VOICE_STEAL_EN
        chk("steal_keys", 32'(vk),   32'(kk(7'd67, 7'd62, 7'd64, 7'd65)));
        chk("steal_on",   32'(von),  32'b0001);
        chk("steal_off",  32'(voff), 32'b0001);
        chk("steal_drop", 32'(drop), 32'd0);
`else
        chk("full_keys",  32'(vk),   32'(kk(7'd60, 7'd62, 7'd64, 7'd65)));
        chk("full_on",    32'(von),  32'd0);
        chk("full_off",   32'(voff), 32'd0);
        chk("full_drop",  32'(drop), 32'd1);
`endif
        @(negedge clk);
        chk("full_drop_end", 32'(drop), 32'd0);

        // reset asserted during SEARCH
        kv = 1'b1; ki = 7'd10;
        @(negedge clk);
        kv = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_active", 32'(va),   32'd0);
        chk("midrst_key",    32'(vk),   32'd0);
        chk("midrst_on",     32'(von),  32'd0);
        chk("midrst_off",    32'(voff), 32'd0);
        chk("midrst_busy0",  32'(busy), 32'd0);
        chk("midrst_drop",   32'(drop), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_lost", 32'(va), 32'd0);
        strobe(7'd10);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_next_active", 32'(va),  32'b0001);
        chk("midrst_next_key",     32'(vk),  32'(kk(7'd10, 7'd0, 7'd0, 7'd0)));
        chk("midrst_next_on",      32'(von), 32'b0001);

        // timeout release at age 100
        reset_all();
        strobe_to(7'd70);
        @(negedge clk);
        @(negedge clk);
        chk("to_alloc_on",     32'(von2), 32'b0001);
        chk("to_alloc_active", 32'(va2),  32'b0001);
        repeat (100) @(negedge clk);
        chk("to_pre_active", 32'(va2),   32'b0001);
        chk("to_pre_off",    32'(voff2), 32'd0);
        @(negedge clk);
        chk("to_off_pulse", 32'(voff2), 32'b0001);
        chk("to_cleared",   32'(va2),   32'd0);
        @(negedge clk);
        chk("to_off_end",   32'(voff2), 32'd0);

        // retrigger whose UPDATE lands on the timeout cycle
        strobe_to(7'd70);
        @(negedge clk);
        @(negedge clk);
        chk("rt_alloc_on", 32'(von2), 32'b0001);
        repeat (97) @(negedge clk);
        strobe_to(7'd70);
        cnt = int'(voff2[0]);
        @(negedge clk);
        chk("rt_upd_active", 32'(va2), 32'b0001);
        cnt += int'(voff2[0]);
        @(negedge clk);
        chk("rt_off_pulse", 32'(voff2), 32'b0001);
        chk("rt_cleared",   32'(va2),   32'd0);
        cnt += int'(voff2[0]);
        repeat (4) begin
            @(negedge clk);
            cnt += int'(voff2[0]);
        end
        chk("rt_single_off", 32'(cnt), 32'd1);
        chk("rt_no_realloc", 32'(va2), 32'd0);

        // retrigger whose SEARCH sees a slot that times out before UPDATE
        strobe_to(7'd70);
        @(negedge clk);
        @(negedge clk);
        repeat (98) @(negedge clk);
        strobe_to(7'd70);
        cnt = 0;
        repeat (6) begin
            cnt += int'(voff2[0]);
            @(negedge clk);
        end
        chk("late_single_off", 32'(cnt),  32'd1);
        chk("late_inactive",   32'(va2),  32'd0);
        chk("late_no_on",      32'(von2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
